// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the binary-number-game controller.
//   ST_*     : numeric state encodings as seen on the 'state' output
//   state_t  : 2-bit enumerated FSM state type built on those encodings
// ---------------------------------------------------------------------------
package game_pkg;

  localparam logic [1:0] ST_WELCOME = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_PLAY    = 2'd2;
  localparam logic [1:0] ST_LOSE    = 2'd3;

  typedef enum logic [1:0] {
    WELCOME = ST_WELCOME,
    READY   = ST_READY,
    PLAY    = ST_PLAY,
    LOSE    = ST_LOSE
  } state_t;

endpackage

// File: rtl/game_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_param_if
// Bundles the controller's handshake with the debouncer, the comparator
// and the countdown timer.
//   guess_b, cmp_r, end_f : environment -> controller
//   state, level, best,
//   lives, set_f, set_v   : controller -> environment
// Modports:
//   master : the surrounding system (debouncer, comparator, timer, display)
//   slave  : the game controller itself
// ---------------------------------------------------------------------------
interface game_ctrl_param_if #(
  parameter int LEVEL_W = 8,
  parameter int TIME_W  = 5
);

  logic               guess_b;
  logic               cmp_r;
  logic               end_f;
  logic [1:0]         state;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] best;
  logic [1:0]         lives;
  logic               set_f;
  logic [TIME_W-1:0]  set_v;

  modport master (
    output guess_b, cmp_r, end_f,
    input  state, level, best, lives, set_f, set_v
  );

  modport slave (
    input  guess_b, cmp_r, end_f,
    output state, level, best, lives, set_f, set_v
  );

endinterface

// File: rtl/rise_det.sv
// ---------------------------------------------------------------------------
// rise_det
// One-bit rising-edge detector. The history flop follows 'd' every cycle;
// 'rise' is high for the cycle in which 'd' is 1 and was 0 on the previous
// clock.
//   clk  : clock
//   rst  : asynchronous active-high reset (history flop cleared)
//   d    : level input
//   rise : combinational rising-edge indication
// ---------------------------------------------------------------------------
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // History flop: remembers last cycle's level so a held input reports a
  // single rise only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_ctrl_param.sv
// ---------------------------------------------------------------------------
// game_ctrl_param
// Game controller FSM: Welcome -> Ready -> Play -> Lose, tracking the level,
// the best level since reset, and computing the countdown preload for each
// round as max(BASE_TIME - TIME_STEP*level, MIN_TIME) saturated to TIME_W.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : game_ctrl_param_if.slave
//            guess_b (in)  debounced guess button, acted on at rising edge
//            cmp_r   (in)  comparator result, 1 = guess correct
//            end_f   (in)  timer expired, acted on at rising edge
//            state   (out) 0 Welcome, 1 Ready, 2 Play, 3 Lose
//            level   (out) current level
//            best    (out) highest level since reset
//            lives   (out) remaining lives (0 when lives are disabled)
//            set_f   (out) one-cycle timer-load strobe
//            set_v   (out) timer preload, held after the strobe
//
// Build option:
//   GAME_LIVES_EN : when defined, a wrong guess costs one life and the round
//                   restarts from Ready; losing the last life goes to Lose.
//                   When undefined, lives reads 0 and a wrong guess loses.
// ---------------------------------------------------------------------------
module game_ctrl_param
  import game_pkg::*;
#(
  parameter int LEVEL_W   = 8,
  parameter int TIME_W    = 5,
  parameter int BASE_TIME = 30,
  parameter int TIME_STEP = 2,
  parameter int MIN_TIME  = 3,
  parameter int LIVES     = 3
) (
  input logic              clk,
  input logic              rst,
  game_ctrl_param_if.slave bus
);

  // Signed working width wide enough that BASE_TIME - TIME_STEP*level can go
  // negative without wrapping.
  localparam int STEP_W  = $clog2(TIME_STEP + 1);
  localparam int PROD_W  = LEVEL_W + STEP_W;
  localparam int ARITH_W = ((TIME_W > PROD_W) ? TIME_W : PROD_W) + 2;

  localparam logic [TIME_W-1:0]  RESET_SET_V = TIME_W'(BASE_TIME);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = {LEVEL_W{1'b1}};

  // The lives counter is only two bits wide, so LIVES must fit in it.
  if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
    $error("game_ctrl_param: LIVES must be in the range 1..3");
  end

  // Round preload: subtract in signed arithmetic, clamp low to MIN_TIME,
  // then saturate to the largest value the timer port can carry.
  function automatic logic [TIME_W-1:0] calc_preload(input logic [LEVEL_W-1:0] lvl);
    logic signed [ARITH_W-1:0] base_s;
    logic signed [ARITH_W-1:0] step_s;
    logic signed [ARITH_W-1:0] lvl_s;
    logic signed [ARITH_W-1:0] diff_s;
    logic signed [ARITH_W-1:0] min_s;
    logic signed [ARITH_W-1:0] max_s;
    base_s = ARITH_W'(BASE_TIME);
    step_s = ARITH_W'(TIME_STEP);
    lvl_s  = $signed(ARITH_W'(lvl));
    min_s  = ARITH_W'(MIN_TIME);
    max_s  = ARITH_W'((1 << TIME_W) - 1);
    diff_s = base_s - (step_s * lvl_s);
    if (diff_s < min_s) begin
      diff_s = min_s;
    end
    if (diff_s > max_s) begin
      diff_s = max_s;
    end
    return diff_s[TIME_W-1:0];
  endfunction

  logic g_rise;
  logic e_rise;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] best_q,  best_d;
  logic               set_f_q, set_f_d;
  logic [TIME_W-1:0]  set_v_q, set_v_d;

`ifdef GAME_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  logic [1:0] lives_q, lives_d;
`endif

  rise_det u_guess_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.guess_b),
    .rise (g_rise)
  );

  rise_det u_end_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.end_f),
    .rise (e_rise)
  );

  // Next-state and next-output logic. Everything is held by default; the
  // timer strobe defaults low so it can only pulse on Ready -> Play.
  // A timeout edge in Play wins over a simultaneous guess edge.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    set_f_d = 1'b0;
    set_v_d = set_v_q;
`ifdef GAME_LIVES_EN
    lives_d = lives_q;
`endif

    unique case (state_q)
      WELCOME: begin
        if (g_rise) begin
          state_d = READY;
        end
      end

      READY: begin
        if (g_rise) begin
          state_d = PLAY;
          set_f_d = 1'b1;
          set_v_d = calc_preload(level_q);
        end
      end

      PLAY: begin
        if (e_rise) begin
          state_d = LOSE;
        end else if (g_rise) begin
          if (bus.cmp_r && !bus.end_f) begin
            state_d = READY;
            if (level_q != LEVEL_MAX) begin
              level_d = level_q + LEVEL_W'(1);
            end
          end else begin
`ifdef GAME_LIVES_EN
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              state_d = READY;
            end else begin
              lives_d = 2'd0;
              state_d = LOSE;
            end
`else
            state_d = LOSE;
`endif
          end
        end
      end

      LOSE: begin
        if (g_rise) begin
          state_d = READY;
          level_d = '0;
`ifdef GAME_LIVES_EN
          lives_d = LIVES_INIT;
`endif
        end
      end

      default: begin
        state_d = WELCOME;
      end
    endcase

    // Best follows the new level in the same clock it is written.
    best_d = (level_d > best_q) ? level_d : best_q;
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WELCOME;
      level_q <= '0;
      best_q  <= '0;
      set_f_q <= 1'b0;
      set_v_q <= RESET_SET_V;
`ifdef GAME_LIVES_EN
      lives_q <= LIVES_INIT;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      best_q  <= best_d;
      set_f_q <= set_f_d;
      set_v_q <= set_v_d;
`ifdef GAME_LIVES_EN
      lives_q <= lives_d;
`endif
    end
  end

  assign bus.state = state_q;
  assign bus.level = level_q;
  assign bus.best  = best_q;
  assign bus.set_f = set_f_q;
  assign bus.set_v = set_v_q;
`ifdef GAME_LIVES_EN
  assign bus.lives = lives_q;
`else
  assign bus.lives = 2'd0;
`endif

endmodule

// File: tb/tb_game_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl_param
// Self-checking bench for game_ctrl_param with default parameters
// (LEVEL_W=8, TIME_W=5, BASE_TIME=30, TIME_STEP=2, MIN_TIME=3, LIVES=3).
// Expected values are hand-computed; the lives-dependent expectations
// follow GAME_LIVES_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_game_ctrl_param;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

`ifdef GAME_LIVES_EN
  localparam bit LIVES_ON = 1'b1;
`else
  localparam bit LIVES_ON = 1'b0;
`endif
  localparam logic [1:0] L0 = LIVES_ON ? 2'd3 : 2'd0;
  localparam logic [1:0] LW = LIVES_ON ? 2'd2 : 2'd0;
  localparam logic [1:0] SW = LIVES_ON ? 2'd1 : 2'd3;

  game_ctrl_param_if #(.LEVEL_W(8), .TIME_W(5)) gif ();

  game_ctrl_param #(
    .LEVEL_W   (8),
    .TIME_W    (5),
    .BASE_TIME (30),
    .TIME_STEP (2),
    .MIN_TIME  (3),
    .LIVES     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       g;
    logic       c;
    logic       e;
    logic [1:0] st;
    logic [7:0] lvl;
    logic [7:0] bst;
    logic [1:0] lv;
    logic       sf;
    logic [4:0] sv;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  // Drive inputs on the falling edge, let one rising edge act, and return
  // on the next falling edge so outputs are sampled away from the clock.
  task automatic applyStimulus(input logic g, input logic c, input logic e);
    gif.guess_b = g;
    gif.cmp_r   = c;
    gif.end_f   = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int id,
                             input logic [1:0] st, input logic [7:0] lvl,
                             input logic [7:0] bst, input logic [1:0] lv,
                             input logic sf, input logic [4:0] sv);
    logic [25:0] act;
    logic [25:0] exp;
    act = {gif.state, gif.level, gif.best, gif.lives, gif.set_f, gif.set_v};
    exp = {st, lvl, bst, lv, sf, sv};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s#%0d: got st=%0d lvl=%0d best=%0d lives=%0d set_f=%0d set_v=%0d, want st=%0d lvl=%0d best=%0d lives=%0d set_f=%0d set_v=%0d",
               name, id, gif.state, gif.level, gif.best, gif.lives, gif.set_f, gif.set_v,
               st, lvl, bst, lv, sf, sv);
    end
  endtask

  task automatic doReset(input int id);
    rst = 1'b1;
    gif.guess_b = 1'b0;
    gif.cmp_r   = 1'b0;
    gif.end_f   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", id, 2'd0, 8'd0, 8'd0, L0, 1'b0, 5'd30);
    rst = 1'b0;
  endtask

  // Ready -> Play -> correct guess -> Ready.
  task automatic winRound();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    gif.guess_b = 1'b0;
    gif.cmp_r   = 1'b0;
    gif.end_f   = 1'b0;

    //          g     c     e     st    lvl   bst   lv  sf    sv
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, L0, 1'b0, 5'd30};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0, L0, 1'b0, 5'd30};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0, L0, 1'b0, 5'd30};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0, L0, 1'b1, 5'd30};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0, L0, 1'b0, 5'd30};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd1, 8'd1, 8'd1, L0, 1'b0, 5'd30};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 8'd1, L0, 1'b0, 5'd30};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd2, 8'd1, 8'd1, L0, 1'b1, 5'd28};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'd1, 8'd1, L0, 1'b0, 5'd28};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd3, 8'd1, 8'd1, L0, 1'b0, 5'd28};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd3, 8'd1, 8'd1, L0, 1'b0, 5'd28};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd0, 8'd1, L0, 1'b0, 5'd28};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd1, L0, 1'b0, 5'd28};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd1, L0, 1'b1, 5'd30};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd2, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'd0, 8'd1, L0, 1'b1, 5'd30};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'd0, 8'd1, L0, 1'b0, 5'd30};
    tbl[22] = '{1'b1, 1'b1, 1'b1, SW,   8'd0, 8'd1, LW, 1'b0, 5'd30};
    tbl[23] = '{1'b0, 1'b0, 1'b1, SW,   8'd0, 8'd1, LW, 1'b0, 5'd30};

    // Basic flow, level step, timeout priority, ignored timeouts and a
    // correct guess made after the timer already expired.
    doReset(0);
    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i].g, tbl[i].c, tbl[i].e);
      checkOutput("table", i, tbl[i].st, tbl[i].lvl, tbl[i].bst,
                  tbl[i].lv, tbl[i].sf, tbl[i].sv);
    end

    // Preload clamping and level saturation.
    doReset(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) winRound();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lvl13_play", 0, 2'd2, 8'd13, 8'd13, L0, 1'b1, 5'd4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lvl14_ready", 0, 2'd1, 8'd14, 8'd14, L0, 1'b0, 5'd4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lvl14_play", 0, 2'd2, 8'd14, 8'd14, L0, 1'b1, 5'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) winRound();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lvl20_play", 0, 2'd2, 8'd20, 8'd20, L0, 1'b1, 5'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 234; i++) winRound();
    checkOutput("lvl255", 0, 2'd1, 8'd255, 8'd255, L0, 1'b0, 5'd3);
    winRound();
    checkOutput("lvl_sat", 0, 2'd1, 8'd255, 8'd255, L0, 1'b0, 5'd3);

    // Wrong guesses, with and without lives.
    doReset(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrong_enter", 0, 2'd2, 8'd0, 8'd0, L0, 1'b1, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrong1", 0, SW, 8'd0, 8'd0, LW, 1'b0, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef GAME_LIVES_EN
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrong2", 0, 2'd1, 8'd0, 8'd0, 2'd1, 1'b0, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrong3", 0, 2'd3, 8'd0, 8'd0, 2'd0, 1'b0, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lose_restart", 0, 2'd1, 8'd0, 8'd0, L0, 1'b0, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a level-5 round.
    doReset(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) winRound();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lvl5_play", 0, 2'd2, 8'd5, 8'd5, L0, 1'b1, 5'd20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 0, 2'd0, 8'd0, 8'd0, L0, 1'b0, 5'd30);
    @(negedge clk);
    checkOutput("rst_held", 0, 2'd0, 8'd0, 8'd0, L0, 1'b0, 5'd30);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst", 0, 2'd0, 8'd0, 8'd0, L0, 1'b0, 5'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst", 1, 2'd0, 8'd0, 8'd0, L0, 1'b0, 5'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
